// File: rtl/alu_ex_stage_p.sv
// alu_ex_stage_p: execute-stage ALU with registered result/flags and an iterative shift-add multiplier
module alu_ex_stage_p #(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       op_dec,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] ans_ex,
  output logic [3:0]       flag_ex,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] DM_data,
  output logic             busy
);
  localparam logic [5:0] OP_OUT = 6'b010111;
  localparam logic [5:0] OP_MUL = 6'b100000;
  typedef enum logic {IDLE, MULS} state_t;
  state_t state, state_n;
  logic [2*WIDTH-1:0] ma, acc, acc_n;
  logic [WIDTH-1:0] mb, res;
  logic [SHW-1:0] cnt, sh;
  logic [WIDTH:0] add_s, sub_s;
  logic [3:0] flg, mflg;
  logic take, ld_ans, logic_f, last;
  assign busy = state == MULS;
  assign in_ready = ~busy;
  assign take = in_valid && in_ready;
  assign last = busy && cnt == SHW'(WIDTH-1);
  assign sh = B[SHW-1:0];
  assign add_s = {1'b0, A} + {1'b0, B};
  assign sub_s = {1'b0, A} + {1'b0, ~B} + 1'b1;
  // one multiplier bit per cycle, LSB first, into a double-width accumulator
  assign acc_n = acc + (mb[0] ? ma : '0);
  assign mflg = {acc_n[WIDTH-1], 1'b0, |acc_n[2*WIDTH-1:WIDTH], ~|acc_n[WIDTH-1:0]};
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = (take && op_dec == OP_MUL) ? MULS : IDLE;
    else state_n = last ? IDLE : MULS;
  end
  always_comb begin
    res = '0;
    flg = flag_ex;
    ld_ans = 1'b1;
    logic_f = 1'b0;
    case (op_dec)
      6'b000000: begin
        res = add_s[WIDTH-1:0];
        flg = {add_s[WIDTH-1], add_s[WIDTH], (A[WIDTH-1] == B[WIDTH-1]) && (add_s[WIDTH-1] != A[WIDTH-1]), ~|add_s[WIDTH-1:0]};
      end
      6'b000001: begin
        res = sub_s[WIDTH-1:0];
        flg = {sub_s[WIDTH-1], sub_s[WIDTH], (A[WIDTH-1] != B[WIDTH-1]) && (sub_s[WIDTH-1] != A[WIDTH-1]), ~|sub_s[WIDTH-1:0]};
      end
      6'b000010: begin res = B; logic_f = 1'b1; end
      6'b000100: begin res = A & B; logic_f = 1'b1; end
      6'b000101: begin res = A | B; logic_f = 1'b1; end
      6'b000110: begin res = A ^ B; logic_f = 1'b1; end
      6'b000111: begin res = ~B; logic_f = 1'b1; end
      6'b010110: res = data_in;
      6'b011001: begin res = A << sh; logic_f = 1'b1; end
      6'b011010: begin res = A >> sh; logic_f = 1'b1; end
      6'b011011: begin res = $signed(A) >>> sh; logic_f = 1'b1; end
      OP_OUT, 6'b011100, OP_MUL: ld_ans = 1'b0;
      default: ;
    endcase
    if (logic_f) flg = {res[WIDTH-1], 2'b00, ~|res};
  end
  always_ff @(posedge clk)
    if (reset) begin
      out_valid <= 1'b0;
      ans_ex <= '0;
      flag_ex <= '0;
      data_out <= '0;
      DM_data <= '0;
      ma <= '0;
      mb <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      out_valid <= 1'b0;
      if (busy) begin
        acc <= acc_n;
        ma <= ma << 1;
        mb <= mb >> 1;
        cnt <= cnt + 1'b1;
        if (last) begin
          ans_ex <= acc_n[WIDTH-1:0];
          flag_ex <= mflg;
          out_valid <= 1'b1;
        end
      end else if (take) begin
        DM_data <= B;
        if (op_dec == OP_MUL) begin
          ma <= {{WIDTH{1'b0}}, A};
          mb <= B;
          acc <= '0;
          cnt <= '0;
        end else begin
          out_valid <= 1'b1;
          flag_ex <= flg;
          if (ld_ans) ans_ex <= res;
          if (op_dec == OP_OUT) data_out <= A;
        end
      end
    end
endmodule

// File: tb/tb_alu_ex_stage_p.sv
// tb_alu_ex_stage_p: directed and randomized checks of alu_ex_stage_p against an arithmetic reference model
module tb_alu_ex_stage_p;
  logic clk = 0, reset = 1, in_valid = 0;
  logic [5:0] op_dec = '0;
  logic [15:0] A = '0, B = '0, data_in = '0;
  logic in_ready, out_valid, busy;
  logic [15:0] ans_ex, data_out, DM_data;
  logic [3:0] flag_ex;
  int checks = 0, errors = 0;
  logic [15:0] e_ans = '0, e_dout = '0, e_dm = '0;
  logic [3:0] e_flg = '0;

  alu_ex_stage_p #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op_dec(op_dec),
    .A(A), .B(B), .data_in(data_in), .out_valid(out_valid), .ans_ex(ans_ex), .flag_ex(flag_ex),
    .data_out(data_out), .DM_data(DM_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Flags are {N,C,V,Z}; arithmetic done in 32-bit ints so carry/overflow fall out directly
  function automatic void model(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b, input logic [15:0] d);
    int unsigned s, p;
    int sv, sh;
    logic [15:0] r, nb;
    logic lg;
    sh = int'(b[3:0]);
    nb = ~b;
    lg = 1'b0;
    r = '0;
    e_dm = b;
    case (op)
      6'h00: begin
        s = 32'(a) + 32'(b); r = s[15:0];
        sv = int'($signed(a)) + int'($signed(b));
        e_flg = {r[15], s > 32'hFFFF, sv > 32767 || sv < -32768, r == 16'h0}; e_ans = r;
      end
      6'h01: begin
        s = 32'(a) + 32'(nb) + 1; r = s[15:0];
        sv = int'($signed(a)) - int'($signed(b));
        e_flg = {r[15], s > 32'hFFFF, sv > 32767 || sv < -32768, r == 16'h0}; e_ans = r;
      end
      6'h02: begin r = b; lg = 1'b1; end
      6'h04: begin r = a & b; lg = 1'b1; end
      6'h05: begin r = a | b; lg = 1'b1; end
      6'h06: begin r = a ^ b; lg = 1'b1; end
      6'h07: begin r = nb; lg = 1'b1; end
      6'h16: e_ans = d;
      6'h17: e_dout = a;
      6'h19: begin r = a << sh; lg = 1'b1; end
      6'h1A: begin r = a >> sh; lg = 1'b1; end
      6'h1B: begin r = 16'($signed(a) >>> sh); lg = 1'b1; end
      6'h1C: ;
      6'h20: begin
        p = 32'(a) * 32'(b); r = p[15:0];
        e_ans = r; e_flg = {r[15], 1'b0, p[31:16] != 16'h0, r == 16'h0};
      end
      default: e_ans = '0;
    endcase
    if (lg) begin
      e_ans = r;
      e_flg = {r[15], 2'b00, r == 16'h0};
    end
  endfunction

  task automatic res_chk(input string tag);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_ans"}, ans_ex, e_ans);
    chk({tag, "_flag"}, flag_ex, e_flg);
    chk({tag, "_dout"}, data_out, e_dout);
    chk({tag, "_dm"}, DM_data, e_dm);
  endtask

  // Present one op and leave in_valid high so the next call issues back-to-back
  task automatic run(input string tag, input logic [5:0] op, input logic [15:0] a, input logic [15:0] b, input logic [15:0] d);
    op_dec = op; A = a; B = b; data_in = d; in_valid = 1;
    chk({tag, "_ready"}, in_ready, 1);
    step;
    model(op, a, b, d);
    if (op == 6'h20) begin
      in_valid = 0;
      chk({tag, "_busy0"}, busy, 1);
      chk({tag, "_dm0"}, DM_data, e_dm);
      for (int i = 1; i < 16; i++) begin
        step;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_nov"}, out_valid, 0);
      end
      step;
      chk({tag, "_done"}, busy, 0);
    end
    res_chk(tag);
  endtask

  task automatic idle;
    in_valid = 0;
    step;
    chk("idle_nov", out_valid, 0);
  endtask

  logic [5:0] opl [15] = '{6'h00, 6'h01, 6'h02, 6'h04, 6'h05, 6'h06, 6'h07, 6'h16,
                           6'h17, 6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h20, 6'h3F};

  initial begin
    repeat (2) step;
    reset = 0;
    chk("rst_ans", ans_ex, 0);
    chk("rst_flag", flag_ex, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_dm", DM_data, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 1);

    run("add", 6'h00, 16'h7FFF, 16'h0001, 16'h0);
    chk("add_const", {ans_ex, flag_ex}, {16'h8000, 4'b1010});
    idle;
    run("sub", 6'h01, 16'h0005, 16'h0005, 16'h0);
    chk("sub_const", {ans_ex, flag_ex}, {16'h0000, 4'b0101});
    run("nop", 6'h1C, 16'h1111, 16'h2222, 16'h0);
    chk("nop_const", {ans_ex, flag_ex}, {16'h0000, 4'b0101});
    run("sra", 6'h1B, 16'h8010, 16'd4, 16'h0);
    chk("sra_const", ans_ex, 16'hF801);
    run("srl", 6'h1A, 16'h8010, 16'd4, 16'h0);
    chk("srl_const", ans_ex, 16'h0801);
    run("sll", 6'h19, 16'h0001, 16'd15, 16'h0);
    chk("sll_const", {ans_ex, flag_ex}, {16'h8000, 4'b1000});
    run("sra15", 6'h1B, 16'h8000, 16'd15, 16'h0);
    chk("sra15_const", ans_ex, 16'hFFFF);
    run("sll0", 6'h19, 16'hA5A5, 16'h0010, 16'h0);
    chk("sll0_const", ans_ex, 16'hA5A5);
    run("out", 6'h17, 16'h1234, 16'h0, 16'h0);
    chk("out_const", data_out, 16'h1234);
    run("in", 6'h16, 16'h0, 16'h0, 16'h0000);
    chk("in_const", ans_ex, 16'h0000);
    run("undef", 6'h3F, 16'h5555, 16'h0, 16'h0);
    chk("undef_const", ans_ex, 16'h0000);
    idle;

    // MUL with an ADD held on the issue side during the whole multiply
    op_dec = 6'h20; A = 16'h012C; B = 16'h012C; in_valid = 1;
    step;
    model(6'h20, 16'h012C, 16'h012C, 16'h0);
    chk("mul_busy", busy, 1);
    chk("mul_nready", in_ready, 0);
    chk("mul_dm", DM_data, 16'h012C);
    op_dec = 6'h00; A = 16'h0003; B = 16'h0004;
    for (int i = 1; i < 16; i++) begin
      step;
      chk("mul_hold_busy", busy, 1);
      chk("mul_hold_nov", out_valid, 0);
      chk("mul_hold_dm", DM_data, 16'h012C);
    end
    step;
    chk("mul_const", {ans_ex, flag_ex}, {16'h5F90, 4'b0010});
    res_chk("mul");
    chk("mul_ready", in_ready, 1);
    step;
    model(6'h00, 16'h0003, 16'h0004, 16'h0);
    res_chk("held_add");
    chk("held_add_const", ans_ex, 16'h0007);
    idle;

    // reset in the middle of a multiply
    op_dec = 6'h20; A = 16'hFFFF; B = 16'hFFFF; in_valid = 1;
    step;
    in_valid = 0;
    repeat (7) step;
    reset = 1;
    step;
    reset = 0;
    e_ans = '0; e_flg = '0; e_dout = '0; e_dm = '0;
    chk("rmul_ov", out_valid, 0);
    chk("rmul_all", {ans_ex, flag_ex, data_out, DM_data}, 52'h0);
    chk("rmul_busy", busy, 0);
    chk("rmul_ready", in_ready, 1);
    repeat (12) begin
      step;
      chk("rmul_quiet", {out_valid, busy}, 2'b00);
    end

    for (int n = 0; n < 150; n++) begin
      int k;
      logic [5:0] op;
      logic [15:0] a, b;
      k = $urandom_range(0, 15);
      op = (k == 15) ? 6'($urandom) : opl[k];
      a = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom);
      if ($urandom_range(0, 9) == 0) b = a;
      run("rnd", op, a, b, 16'($urandom));
      if ($urandom_range(0, 3) == 0) idle;
    end
    idle;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_ex_stage_p.md
# alu_ex_stage_p

Parametrised execute-stage ALU for the MIPS-style pipeline: accepts one decoded operation per cycle via a valid/ready handshake, registers result, store data and a four-bit flag register. Adds an iterative multi-cycle multiplier that stalls the issue side while busy. It sits between decode/register read and the data-memory stage.

## Interface
- WIDTH, 16, datapath width; must be ≥4 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  decode presents an operation.
- in_ready  output  1  stage can accept; equals ~busy.
- op_dec  input  6  decoded opcode.
- A, B  input  WIDTH  operands.
- data_in  input  WIDTH  external input-port value.
- out_valid  output  1  one-cycle pulse: ans_ex/flag_ex hold a fresh result.
- ans_ex  output  WIDTH  registered result.
- flag_ex  output  4  registered flags {N,C,V,Z}.
- data_out  output  WIDTH  registered output-port value.
- DM_data  output  WIDTH  registered store data (B of last accepted op).
- busy  output  1  multiplier running.

## Operation
- Accept = in_valid && in_ready. Non-accepted cycles change no register except out_valid←0.
- Opcodes: 000000 ADD A+B; 000001 SUB A−B; 000010 MOV B; 000100 AND; 000101 OR; 000110 XOR; 000111 NOT ~B; 010110 IN data_in; 010111 OUT (data_out←A, ans_ex unchanged); 011001 SLL A<<B[SHW-1:0]; 011010 SRL; 011011 SRA (sign-filled); 011100 NOP; 100000 MUL (low WIDTH bits of unsigned A×B); any other: ans_ex←0, flags unchanged.
- Flags: ADD/SUB update all: Z=res==0, N=res[WIDTH-1], C=carry-out (SUB: 1 = no borrow, computed A+~B+1), V=signed overflow. Logic/MOV/NOT/shifts: Z,N updated, C=V=0. MUL: Z,N from low product, V=1 if high product half ≠0, C=0. IN, OUT, NOP, undefined: all flags preserved.
- DM_data←B on every accept, including MUL.
- FSM: IDLE, MUL. IDLE+accept MUL → MUL, latch A,B, acc←0, cnt←0, busy←1. MUL: each cycle shift-add one multiplier bit (LSB first) into 2·WIDTH accumulator, cnt++. On the cycle cnt==WIDTH-1: write ans_ex/flags, out_valid←1, busy←0, → IDLE.
- in_valid while busy is ignored; the issuer holds the op until in_ready.

## Timing
- Reset: ans_ex, data_out, DM_data = 0; flag_ex = 4'b0000; out_valid = 0; busy = 0; FSM = IDLE; in_ready = 1 in the first cycle after reset deasserts.
- Single-cycle ops: accept at edge k → results and out_valid=1 after edge k; throughput 1/cycle.
- MUL: accept at edge k → busy=1 from k to k+WIDTH−1; result and out_valid=1 after edge k+WIDTH; in_ready=1 in that same cycle, so a new op may be accepted at edge k+WIDTH+1... i.e. on the edge that ends the out_valid cycle.
- Reset during MUL: aborts, no out_valid, all registers at reset values next cycle.
- OUT pulses out_valid with ans_ex unchanged.
- Shift by 0 returns A; SRA by WIDTH−1 yields all-sign bits.

## Test plan
- ADD 0x7FFF+0x0001 → ans_ex 0x8000, flags N=1,C=0,V=1,Z=0, out_valid one cycle after accept for exactly one cycle.
- SUB 0x0005−0x0005 → ans_ex 0x0000, Z=1,C=1,V=0,N=0; following NOP → flags unchanged, ans_ex unchanged.
- A=0x8010,B=4: SRA → 0xF801, SRL → 0x0801; SLL 0x0001 by 15 → 0x8000, N=1, C=V=0; back-to-back issue with no bubbles.
- MUL 300×300 (0x012C) → ans_ex 0x5F90, V=1, Z=0; busy for 16 cycles, out_valid exactly 16 cycles after accept; an ADD held on in_valid meanwhile is accepted only after in_ready returns, and DM_data = 0x012C after the MUL accept.
- MUL accepted, reset asserted 8 cycles later → no out_valid, all outputs 0, busy=0, in_ready=1 next cycle.
- OUT A=0x1234 → data_out 0x1234, ans_ex/flags unchanged; IN data_in=0x0000 → ans_ex 0, Z unchanged; undefined opcode 111111 → ans_ex 0, flags unchanged.
